// File: rtl/sdram_arbiter_if.sv
// Requester A/B, SDRAM-controller and status signals of the two-port line arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface sdram_arbiter_if #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 256
);
  logic                  a_start;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_we;
  logic                  a_done;
  logic [DATA_WIDTH-1:0] a_q;

  logic                  b_start;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_we;
  logic                  b_done;
  logic [DATA_WIDTH-1:0] b_q;

  logic                  sdc_start;
  logic [ADDR_WIDTH-1:0] sdc_addr;
  logic [DATA_WIDTH-1:0] sdc_data;
  logic                  sdc_we;
  logic                  sdc_done;
  logic [DATA_WIDTH-1:0] sdc_q;

  logic                  busy;
  logic                  grant_b;

  modport slave (
    input  a_start, a_addr, a_data, a_we,
    output a_done, a_q,
    input  b_start, b_addr, b_data, b_we,
    output b_done, b_q,
    output sdc_start, sdc_addr, sdc_data, sdc_we,
    input  sdc_done, sdc_q,
    output busy, grant_b
  );

  modport master (
    output a_start, a_addr, a_data, a_we,
    input  a_done, a_q,
    output b_start, b_addr, b_data, b_we,
    input  b_done, b_q,
    input  sdc_start, sdc_addr, sdc_data, sdc_we,
    output sdc_done, sdc_q,
    input  busy, grant_b
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between two whole-line requesters.
// One transaction at a time through the controller's start/done handshake; all outputs registered.
module sdram_arbiter #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 256
) (
  input logic           clk,
  input logic           reset,
  sdram_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic                  last_grant;
  logic                  pick_b;

  logic                  a_done_r;
  logic                  b_done_r;
  logic [DATA_WIDTH-1:0] a_q_r;
  logic [DATA_WIDTH-1:0] b_q_r;
  logic                  sdc_start_r;
  logic [ADDR_WIDTH-1:0] sdc_addr_r;
  logic [DATA_WIDTH-1:0] sdc_data_r;
  logic                  sdc_we_r;
  logic                  busy_r;
  logic                  grant_b_r;

  // B wins when it is the lone requester, or on a tie when A was served last.
  always_comb begin
    pick_b = bus.b_start & (~bus.a_start | ~last_grant);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      a_done_r    <= 1'b0;
      b_done_r    <= 1'b0;
      a_q_r       <= '0;
      b_q_r       <= '0;
      sdc_start_r <= 1'b0;
      sdc_addr_r  <= '0;
      sdc_data_r  <= '0;
      sdc_we_r    <= 1'b0;
      busy_r      <= 1'b0;
      grant_b_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.a_start | bus.b_start) begin
            sdc_addr_r  <= pick_b ? bus.b_addr : bus.a_addr;
            sdc_data_r  <= pick_b ? bus.b_data : bus.a_data;
            sdc_we_r    <= pick_b ? bus.b_we   : bus.a_we;
            sdc_start_r <= 1'b1;
            grant_b_r   <= pick_b;
            last_grant  <= pick_b;
            busy_r      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          sdc_start_r <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          if (bus.sdc_done) begin
            if (grant_b_r) begin
              b_q_r    <= bus.sdc_q;
              b_done_r <= 1'b1;
            end else begin
              a_q_r    <= bus.sdc_q;
              a_done_r <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          // Start levels are not sampled here, so a held start cannot double-grant.
          a_done_r <= 1'b0;
          b_done_r <= 1'b0;
          busy_r   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_done    = a_done_r;
  assign bus.b_done    = b_done_r;
  assign bus.a_q       = a_q_r;
  assign bus.b_q       = b_q_r;
  assign bus.sdc_start = sdc_start_r;
  assign bus.sdc_addr  = sdc_addr_r;
  assign bus.sdc_data  = sdc_data_r;
  assign bus.sdc_we    = sdc_we_r;
  assign bus.busy      = busy_r;
  assign bus.grant_b   = grant_b_r;
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Two-requester arbiter in the clk100 domain that shares the single SDRAM controller between the cache controller (port A) and a second 256-bit line master (port B, e.g. a future DMA/GPU fetch engine).
It sequences one whole-line transaction at a time through the controller's start/done handshake.
Ties are resolved round-robin, and each result is returned only to the requester that issued it.

Parameters:
ADDR_WIDTH, 21, line address width (matches the SDRAM controller address).
DATA_WIDTH, 256, line data width.

Ports:
clk  in  1  100 MHz memory clock
reset  in  1  synchronous, active-high reset
a_start  in  1  port A request level; held high until a_done
a_addr  in  ADDR_WIDTH  port A line address; stable while a_start is high
a_data  in  DATA_WIDTH  port A write data
a_we  in  1  port A write enable
a_done  out  1  one-cycle completion pulse to A
a_q  out  DATA_WIDTH  read data for A
b_start  in  1  port B request level
b_addr  in  ADDR_WIDTH  port B line address
b_data  in  DATA_WIDTH  port B write data
b_we  in  1  port B write enable
b_done  out  1  one-cycle completion pulse to B
b_q  out  DATA_WIDTH  read data for B
sdc_start  out  1  one-cycle start pulse to the SDRAM controller
sdc_addr  out  ADDR_WIDTH  address to the controller
sdc_data  out  DATA_WIDTH  write data to the controller
sdc_we  out  1  write enable to the controller
sdc_done  in  1  controller completion pulse
sdc_q  in  DATA_WIDTH  controller read data
busy  out  1  high while a transaction is in ISSUE, WAIT or DONE
grant_b  out  1  owner of the current or last transaction: 0 = A, 1 = B

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- Reset values: state = IDLE. All outputs are 0: done pulses, q buses, sdc_* outputs, busy, grant_b. last_grant is set to B, so A wins the first tie.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States and transitions:
  - IDLE: if exactly one start is high, select that port. If both are high, select the port that is not last_grant. On selection:
    - latch the selected port's addr/data/we into sdc_addr/sdc_data/sdc_we;
    - set sdc_start = 1, grant_b, last_grant, busy = 1;
    - go to ISSUE.
  - ISSUE: one cycle. Clear sdc_start, go to WAIT. sdc_addr/sdc_data/sdc_we stay held.
  - WAIT: hold until sdc_done = 1. Then:
    - latch sdc_q into a_q or b_q per grant_b; the other q is unchanged;
    - set the matching done output to 1;
    - go to DONE.
  - DONE: one cycle. Clear the done pulse and busy, go to IDLE. The requester drops start on this same edge.
- Start-handling rules:
  - Start levels are sampled only in IDLE.
  - A start that is still high in DONE is ignored.
  - The earliest re-grant is therefore the IDLE cycle after DONE.
- Latency: start is seen in IDLE at cycle 0. sdc_start is high in cycle 1. If sdc_done is high in cycle N, done is high in cycle N+1 with q valid, and IDLE is at N+2. Arbiter overhead is 3 cycles per transaction.
- Fairness: under continuous contention, grants strictly alternate A, B, A, B. A lone requester is granted back-to-back with no penalty.
- Result retention:
  - q outputs hold their value until the next completion for that port.
  - sdc_addr/sdc_data/sdc_we keep their last values in IDLE; they are don't-care there.
- Boundary cases:
  - sdc_done in IDLE, ISSUE or DONE is ignored. It causes no done pulse and no state change.
  - Requester inputs change while granted: not allowed. The arbiter uses the values latched at grant.
  - A start that drops before done still completes the transaction, and the done pulse is still issued.
  - Reset in any state immediately returns everything to reset values. A controller transaction already in flight is abandoned, and its later sdc_done is ignored under the IDLE rule.

Test Plan:
- A read only: a_start=1, a_addr=0x00123, a_we=0; controller returns done 8 cycles after start with sdc_q=0xDEAD…BEEF -> sdc_start pulses once with sdc_addr=0x00123, sdc_we=0; a_done pulses once with a_q=0xDEAD…BEEF; b_done stays 0; busy falls to 0 on the cycle after a_done.
- B write: b_start=1, b_addr=0x1FFFFF, b_we=1, b_data all 0xA5 -> sdc_addr=0x1FFFFF, sdc_we=1, sdc_data all 0xA5 held through WAIT; grant_b=1; b_done pulses once; a_q unchanged.
- Contention from reset: a_start and b_start high together, each dropping start after its done and re-raising it 1 cycle later, for 4 transactions -> grant order A, B, A, B; exactly one sdc_start per transaction.
- Back-to-back lone A: a_start re-raised on the cycle after a_done -> next sdc_start exactly 2 cycles after a_done, with the new address.
- Stray sdc_done: sdc_done pulsed while IDLE -> no done pulses, busy stays 0, no state change.
- Reset mid-WAIT: reset asserted for 1 cycle in WAIT, then the old sdc_done arrives -> all outputs return to 0 and the stale done is ignored. A then B requested together afterwards -> A is granted first.
